// File: rtl/mult_div_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit feeding HI/LO.
// One iteration per clock, with start/busy/done handshake and divide-by-zero detection.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mdControl,
    input  logic [WIDTH-1:0] regA_out,
    input  logic [WIDTH-1:0] regB_out,
    output logic [WIDTH-1:0] hi_entrance,
    output logic [WIDTH-1:0] lo_entrance,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    // Upper Booth half carries one guard bit so MIN multiplicands do not overflow.
    localparam int unsigned AccW = 2 * WIDTH + 2;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_div_q, op_div_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [WIDTH:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             dz_q, dz_d, done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0] a_mag, b_mag, quo_fin, rem_fin;
    logic [WIDTH:0]   booth_upper, div_shift, div_diff;

    assign a_mag     = regA_out[WIDTH-1] ? -regA_out : regA_out;
    assign b_mag     = regB_out[WIDTH-1] ? -regB_out : regB_out;
    assign quo_fin   = q_neg_q ? -quo_q : quo_q;
    assign rem_fin   = r_neg_q ? -rem_q : rem_q;
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_diff  = div_shift - mcand_q;

    always_comb begin
        booth_upper = acc_q[AccW-1:WIDTH+1];
        case (acc_q[1:0])
            2'b01:   booth_upper = acc_q[AccW-1:WIDTH+1] + mcand_q;
            2'b10:   booth_upper = acc_q[AccW-1:WIDTH+1] - mcand_q;
            default: booth_upper = acc_q[AccW-1:WIDTH+1];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_div_d = mdControl;
                    cnt_d    = '0;
                    dz_d     = mdControl && (regB_out == '0);
                    state_d  = (mdControl && (regB_out == '0)) ? StFinish : StRun;
                    if (mdControl) begin
                        mcand_d = {1'b0, b_mag};
                        rem_d   = '0;
                        quo_d   = a_mag;
                        q_neg_d = regA_out[WIDTH-1] ^ regB_out[WIDTH-1];
                        r_neg_d = regA_out[WIDTH-1];
                    end else begin
                        mcand_d = {regA_out[WIDTH-1], regA_out};
                        acc_d   = {{(WIDTH + 1){1'b0}}, regB_out, 1'b0};
                    end
                end
            end
            StRun: begin
                if (op_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        rem_d = div_diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {booth_upper[WIDTH], booth_upper, acc_q[WIDTH:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
                // A zero divisor leaves HI/LO untouched.
                if (!dz_q) begin
                    if (op_div_q) begin
                        hi_d = rem_fin;
                        lo_d = quo_fin;
                    end else begin
                        hi_d = acc_q[2*WIDTH:WIDTH+1];
                        lo_d = acc_q[WIDTH:1];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi_entrance = hi_q;
    assign lo_entrance = lo_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_zero    = dz_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: a 32-bit and an 8-bit instance, hand-computed results.
module tb_mult_div_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start32 = 1'b0;
    logic        start8 = 1'b0;
    logic        md = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;

    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic        busy32, done32, dz32, busy8, done8, dz8;

    int n_tests = 0;
    int n_fail = 0;
    int lat;

    always #5 clock = ~clock;

    mult_div_seq #(.WIDTH(32), .CNT_W(6)) u_dut32 (
        .clock       (clock),
        .reset       (reset),
        .start       (start32),
        .mdControl   (md),
        .regA_out    (opa),
        .regB_out    (opb),
        .hi_entrance (hi32),
        .lo_entrance (lo32),
        .busy        (busy32),
        .done        (done32),
        .div_zero    (dz32)
    );

    mult_div_seq #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clock       (clock),
        .reset       (reset),
        .start       (start8),
        .mdControl   (md),
        .regA_out    (opa[7:0]),
        .regB_out    (opb[7:0]),
        .hi_entrance (hi8),
        .lo_entrance (lo8),
        .busy        (busy8),
        .done        (done8),
        .div_zero    (dz8)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Launch one op, perturb operands and pulse start mid-run, return edges until done.
    task automatic do_op(input bit sel8, input logic m, input logic [31:0] a,
                         input logic [31:0] b, output int n);
        @(negedge clock);
        md  = m;
        opa = a;
        opb = b;
        if (sel8) start8 = 1'b1;
        else      start32 = 1'b1;
        @(posedge clock);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
        check_eq("busy_after_accept", sel8 ? busy8 : busy32, 1'b1);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
            if (n == 5) begin
                md  = ~m;
                opa = 32'hDEADBEEF;
                opb = 32'h12345678;
                if (sel8) start8 = 1'b1;
                else      start32 = 1'b1;
            end else begin
                start8  = 1'b0;
                start32 = 1'b0;
            end
        end while ((sel8 ? done8 : done32) == 1'b0 && n < 100);
        check_eq("busy_in_done", sel8 ? busy8 : busy32, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_hi", hi32, 32'h0);
        check_eq("rst_lo", lo32, 32'h0);
        check_eq("rst_busy", busy32, 1'b0);
        check_eq("rst_done", done32, 1'b0);
        check_eq("rst_dz", dz32, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        do_op(0, 1'b0, 32'd7, 32'hFFFFFFFD, lat);
        check_eq("mul7x-3_lat", lat, 33);
        check_eq("mul7x-3_hi", hi32, 32'hFFFFFFFF);
        check_eq("mul7x-3_lo", lo32, 32'hFFFFFFEB);
        check_eq("mul7x-3_dz", dz32, 1'b0);
        @(posedge clock);
        #1;
        check_eq("mul_done_width", done32, 1'b0);

        do_op(0, 1'b0, 32'h80000000, 32'h80000000, lat);
        check_eq("mulmin_hi", hi32, 32'h40000000);
        check_eq("mulmin_lo", lo32, 32'h00000000);

        do_op(0, 1'b1, 32'hFFFFFFF9, 32'd2, lat);
        check_eq("div-7/2_lat", lat, 33);
        check_eq("div-7/2_lo", lo32, 32'hFFFFFFFD);
        check_eq("div-7/2_hi", hi32, 32'hFFFFFFFF);

        do_op(0, 1'b1, 32'd7, 32'hFFFFFFFE, lat);
        check_eq("div7/-2_lo", lo32, 32'hFFFFFFFD);
        check_eq("div7/-2_hi", hi32, 32'h00000001);

        do_op(0, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
        check_eq("divmin_lo", lo32, 32'h80000000);
        check_eq("divmin_hi", hi32, 32'h00000000);
        check_eq("divmin_dz", dz32, 1'b0);

        do_op(0, 1'b0, 32'd7, 32'hFFFFFFFD, lat);
        do_op(0, 1'b1, 32'd5, 32'd0, lat);
        check_eq("div0_lat", lat, 1);
        check_eq("div0_dz", dz32, 1'b1);
        check_eq("div0_hi", hi32, 32'hFFFFFFFF);
        check_eq("div0_lo", lo32, 32'hFFFFFFEB);
        repeat (3) @(posedge clock);
        #1;
        check_eq("div0_dz_hold", dz32, 1'b1);
        check_eq("div0_done_low", done32, 1'b0);

        // Abort a running op with start held high.
        @(negedge clock);
        md      = 1'b0;
        opa     = 32'd3;
        opb     = 32'd5;
        start32 = 1'b1;
        @(posedge clock);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort_hi", hi32, 32'h0);
        check_eq("abort_lo", lo32, 32'h0);
        check_eq("abort_busy", busy32, 1'b0);
        check_eq("abort_done", done32, 1'b0);
        check_eq("abort_dz", dz32, 1'b0);
        @(negedge clock);
        start32 = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        do_op(0, 1'b0, 32'd6, 32'd6, lat);
        check_eq("mul6x6_lo", lo32, 32'h00000024);
        check_eq("mul6x6_hi", hi32, 32'h00000000);
        check_eq("b2b_done_cycle", done32, 1'b1);
        do_op(0, 1'b1, 32'd100, 32'd7, lat);
        check_eq("b2b_lat", lat, 33);
        check_eq("div100/7_lo", lo32, 32'h0000000E);
        check_eq("div100/7_hi", hi32, 32'h00000002);

        do_op(1, 1'b0, 32'h7F, 32'h81, lat);
        check_eq("w8_lat", lat, 9);
        check_eq("w8_hi", hi8, 8'hC0);
        check_eq("w8_lo", lo8, 8'hFF);
        @(posedge clock);
        #1;
        check_eq("w8_done_width", done8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
